// File: rtl/z8_stack_unit_if.sv
// Command/response bundle for z8_stack_unit. The master drives commands and err_clr;
// the slave (the stack) drives ready, the response strobe and the status flags.
interface z8_stack_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             err;
    logic             err_clr;

    modport master (
        output cmd_valid, cmd_op, cmd_data, err_clr,
        input  cmd_ready, rsp_valid, rsp_data, count, full, empty, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, err_clr,
        output cmd_ready, rsp_valid, rsp_data, count, full, empty, err
    );
endinterface

// File: rtl/z8_stack_unit.sv
// Hardware stack engine (PUSH/POP/PEEK) with synchronous-read storage and fill tracking.
// Define Z8_STACK_GUARD_EN to reject overflow/underflow and raise a sticky err flag.
module z8_stack_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    z8_stack_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [AW-1:0] SpOne     = AW'(1);
    localparam logic [CW-1:0] CountOne  = CW'(1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

`ifdef Z8_STACK_GUARD_EN
    localparam bit Guard = 1'b1;
`else
    localparam bit Guard = 1'b0;
`endif

    typedef enum logic [1:0] {
        OpNop  = 2'd0,
        OpPush = 2'd1,
        OpPop  = 2'd2,
        OpPeek = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRd   = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    sp_q, sp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rd_zero_q, rd_zero_d;
    logic [WIDTH-1:0] rd_data_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic          full;
    logic          empty;
    logic          accept;
    logic          we;
    logic          rd_en;
    logic          err_set;
    logic [AW-1:0] rd_addr;
    op_e           op;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign accept  = bus.cmd_valid && (state_q == StIdle);
    assign op      = op_e'(bus.cmd_op);
    assign rd_addr = sp_q - SpOne;

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        count_d     = count_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rd_zero_d   = rd_zero_q;
        we          = 1'b0;
        rd_en       = 1'b0;
        err_set     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (op)
                        OpPush: begin
                            if (Guard && full) begin
                                err_set = 1'b1;
                            end else begin
                                we      = 1'b1;
                                sp_d    = sp_q + SpOne;
                                // Unguarded overflow overwrites but keeps count pinned at DEPTH.
                                count_d = full ? count_q : count_q + CountOne;
                            end
                        end
                        OpPop, OpPeek: begin
                            state_d = StRd;
                            if (Guard && empty) begin
                                err_set   = 1'b1;
                                rd_zero_d = 1'b1;
                            end else begin
                                rd_en     = 1'b1;
                                rd_zero_d = 1'b0;
                                if (op == OpPop) begin
                                    sp_d    = sp_q - SpOne;
                                    count_d = empty ? count_q : count_q - CountOne;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StRd: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_zero_q ? '0 : rd_data_q;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sp_q        <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rd_zero_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rd_zero_q   <= rd_zero_d;
        end
    end

    // Storage is not reset; reset only suppresses any write or read issued that cycle.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[sp_q] <= bus.cmd_data;
        end
        if (rd_en && !rst) begin
            rd_data_q <= mem[rd_addr];
        end
    end

`ifdef Z8_STACK_GUARD_EN
    logic err_q;

    // A new error in the same cycle as err_clr wins, so the flag stays set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (err_q && !bus.err_clr) || err_set;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_guard;
    assign unused_guard = bus.err_clr ^ err_set;
    assign bus.err      = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
endmodule

// File: tb/tb_z8_stack_unit.sv
// Scoreboard bench for z8_stack_unit (WIDTH=8, DEPTH=4); covers both guard builds.
module tb_z8_stack_unit;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] PUSH = 2'd1;
    localparam logic [1:0] POP  = 2'd2;
    localparam logic [1:0] PEEK = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    z8_stack_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

    z8_stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_data %h, required no response (t=%0t)",
                         bus.rsp_data, $time);
            end else begin
                check("rsp_data", 32'(bus.rsp_data), 32'(sb.pop_front()));
            end
        end
    end

    // Issue one command; returns 1 time unit after the accepting edge.
    task automatic cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [W-1:0] exp);
        int waited = 0;
        while (bus.cmd_ready !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited == 8) check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        if (op == POP || op == PEEK) sb.push_back(exp);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        if (op == POP || op == PEEK) check("ready_low_in_rd", 32'(bus.cmd_ready), 32'd0);
        else check("ready_after_push", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_data  = '0;
        bus.err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_err", 32'(bus.err), 32'd0);

        cmd(PUSH, 8'h11, 8'h00);
        check("count_1", 32'(bus.count), 32'd1);
        cmd(PUSH, 8'h22, 8'h00);
        cmd(PUSH, 8'h33, 8'h00);
        check("count_3", 32'(bus.count), 32'd3);
        check("full_3", 32'(bus.full), 32'd0);
        check("empty_3", 32'(bus.empty), 32'd0);

        cmd(NOP, 8'hFF, 8'h00);
        check("nop_count", 32'(bus.count), 32'd3);

        cmd(POP, 8'h00, 8'h33);
        check("pop_count_early", 32'(bus.count), 32'd2);
        cmd(POP, 8'h00, 8'h22);
        cmd(POP, 8'h00, 8'h11);
        idle(2);
        check("drained_empty", 32'(bus.empty), 32'd1);
        check("drained_count", 32'(bus.count), 32'd0);

        cmd(PUSH, 8'hA5, 8'h00);
        cmd(PEEK, 8'h00, 8'hA5);
        cmd(PEEK, 8'h00, 8'hA5);
        idle(2);
        check("peek_count", 32'(bus.count), 32'd1);
        cmd(POP, 8'h00, 8'hA5);
        idle(2);

`ifdef Z8_STACK_GUARD_EN
        cmd(PUSH, 8'h01, 8'h00);
        cmd(PUSH, 8'h02, 8'h00);
        cmd(PUSH, 8'h03, 8'h00);
        cmd(PUSH, 8'h04, 8'h00);
        check("g_full", 32'(bus.full), 32'd1);
        cmd(PUSH, 8'hEE, 8'h00);
        check("g_ovf_count", 32'(bus.count), 32'd4);
        check("g_ovf_err", 32'(bus.err), 32'd1);
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        check("g_err_clr", 32'(bus.err), 32'd0);
        cmd(POP, 8'h00, 8'h04);
        cmd(POP, 8'h00, 8'h03);
        cmd(POP, 8'h00, 8'h02);
        cmd(POP, 8'h00, 8'h01);
        cmd(POP, 8'h00, 8'h00);
        check("g_unf_err", 32'(bus.err), 32'd1);
        check("g_unf_count", 32'(bus.count), 32'd0);
        cmd(PEEK, 8'h00, 8'h00);
        idle(2);
        bus.err_clr = 1'b1;
        cmd(POP, 8'h00, 8'h00);
        bus.err_clr = 1'b0;
        check("g_clr_vs_set", 32'(bus.err), 32'd1);
        idle(2);
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        check("g_err_clr2", 32'(bus.err), 32'd0);
`else
        cmd(PUSH, 8'h01, 8'h00);
        cmd(PUSH, 8'h02, 8'h00);
        cmd(PUSH, 8'h03, 8'h00);
        cmd(PUSH, 8'h04, 8'h00);
        cmd(PUSH, 8'h05, 8'h00);
        check("w_count_sat", 32'(bus.count), 32'd4);
        check("w_full", 32'(bus.full), 32'd1);
        // Fifth push overwrote slot 0; slot 3 still holds 0x04.
        cmd(POP, 8'h00, 8'h05);
        cmd(POP, 8'h00, 8'h04);
        cmd(POP, 8'h00, 8'h03);
        cmd(POP, 8'h00, 8'h02);
        check("w_empty", 32'(bus.empty), 32'd1);
        cmd(POP, 8'h00, 8'h05);
        check("w_unf_count", 32'(bus.count), 32'd0);
        cmd(PEEK, 8'h00, 8'h04);
        idle(2);
        check("w_err_zero", 32'(bus.err), 32'd0);
`endif

        cmd(PUSH, 8'h66, 8'h00);
        check("recover_count", 32'(bus.count), 32'd1);
        cmd(POP, 8'h00, 8'h66);

        cmd(PUSH, 8'h77, 8'h00);
        cmd(POP, 8'h00, 8'h77);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        idle(3);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end
endmodule
